// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues single-cycle-latency
// reads to the shared RAM port, and presents each fetched word behind a
// valid/ready handshake. An all-zero word halts fetching until reset.
module instruction_fetch #(
  parameter int                       INSTRUCTION_SIZE = 16,
  parameter int                       ADDRESS_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_mem_busy,
  output logic                        o_mem_read_enable,
  output logic [ADDRESS_WIDTH-1:0]    o_mem_address,
  input  logic [INSTRUCTION_SIZE-1:0] i_mem_read_data,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic [ADDRESS_WIDTH-1:0]    o_pc,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_halted
);

  localparam logic [1:0] S_REQUEST = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  logic [1:0]                  r_state;
  logic [1:0]                  w_next_state;
  logic [ADDRESS_WIDTH-1:0]    r_pc;
  logic [INSTRUCTION_SIZE-1:0] r_instruction;
  logic [ADDRESS_WIDTH-1:0]    r_out_pc;
  logic                        r_valid;
  logic                        r_halted;
  logic                        w_fire_request;
  logic                        w_word_zero;

  // A read goes out only from REQUEST while the processor is not using the port.
  assign w_fire_request = (r_state == S_REQUEST) && !i_mem_busy;
  assign w_word_zero    = (i_mem_read_data == '0);

  // Gated by reset so no spurious read escapes while reset is held.
  assign o_mem_read_enable = w_fire_request && !i_reset;
  assign o_mem_address     = r_pc;
  assign o_instruction     = r_instruction;
  assign o_pc              = r_out_pc;
  assign o_valid           = r_valid;
  assign o_halted          = r_halted;

  // Next-state selection for the fetch sequencer.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_REQUEST: if (!i_mem_busy) w_next_state = S_WAIT;
      S_WAIT:    w_next_state = w_word_zero ? S_HALTED : S_HOLD;
      S_HOLD:    if (i_ready) w_next_state = S_REQUEST;
      S_HALTED:  w_next_state = S_HALTED;
      default:   w_next_state = S_REQUEST;
    endcase
  end

  // State register; reset returns to REQUEST so fetching restarts at RESET_PC.
  always_ff @(posedge i_clock or posedge i_reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (i_reset) r_state <= S_REQUEST;
    else         r_state <= w_next_state;
  end

  // Datapath: capture the returned word, advance the PC, track valid and halt.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_out_pc      <= RESET_PC;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_word_zero) begin
            // PC is left pointing at the halt word.
            r_halted <= 1'b1;
          end else begin
            r_instruction <= i_mem_read_data;
            r_out_pc      <= r_pc;
            r_valid       <= 1'b1;
            r_pc          <= r_pc + ADDRESS_WIDTH'(1);
          end
        end
        S_HOLD: if (i_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (RESET_PC 0 and 255) share one
// stimulus and one RAM image; a transaction-level model is checked every
// cycle and directed scenarios pin the model with literal expectations.
module tb_instruction_fetch;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_mem_busy = 1'b0;
  logic        i_ready = 1'b0;

  logic        w_rd    [2];
  logic [7:0]  w_addr  [2];
  logic [15:0] w_rdata [2];
  logic [15:0] w_ins   [2];
  logic [7:0]  w_pc    [2];
  logic        w_valid [2];
  logic        w_halt  [2];

  logic [15:0] ram [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clock = ~i_clock;

  instruction_fetch #(.INSTRUCTION_SIZE(16), .ADDRESS_WIDTH(8), .RESET_PC(8'd0)) dut0 (
    .i_clock(i_clock), .i_reset(i_reset), .i_mem_busy(i_mem_busy),
    .o_mem_read_enable(w_rd[0]), .o_mem_address(w_addr[0]),
    .i_mem_read_data(w_rdata[0]), .o_instruction(w_ins[0]), .o_pc(w_pc[0]),
    .o_valid(w_valid[0]), .i_ready(i_ready), .o_halted(w_halt[0])
  );

  instruction_fetch #(.INSTRUCTION_SIZE(16), .ADDRESS_WIDTH(8), .RESET_PC(8'd255)) dut1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_mem_busy(i_mem_busy),
    .o_mem_read_enable(w_rd[1]), .o_mem_address(w_addr[1]),
    .i_mem_read_data(w_rdata[1]), .o_instruction(w_ins[1]), .o_pc(w_pc[1]),
    .o_valid(w_valid[1]), .i_ready(i_ready), .o_halted(w_halt[1])
  );

  // Synchronous-read RAM, one read port per instance.
  always @(posedge i_clock) begin
    if (w_rd[0]) w_rdata[0] <= ram[w_addr[0]];
    if (w_rd[1]) w_rdata[1] <= ram[w_addr[1]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  opc;
    logic [15:0] ins;
    bit          inflight;
    bit          holding;
    bit          halted;
  } mdl_t;

  mdl_t m [2];

  function automatic logic [7:0] rpc_of(int k);
    return (k == 0) ? 8'd0 : 8'd255;
  endfunction

  function automatic mdl_t mreset(logic [7:0] rpc);
    mdl_t s;
    s.pc = rpc; s.opc = rpc; s.ins = '0;
    s.inflight = 0; s.holding = 0; s.halted = 0;
    return s;
  endfunction

  // One clock edge: an outstanding read returns ram[pc]; a held word leaves on
  // ready; an idle fetcher launches a read unless the port is busy.
  function automatic mdl_t mstep(mdl_t s, logic [7:0] rpc);
    logic [15:0] w;
    if (i_reset) return mreset(rpc);
    if (s.halted) return s;
    if (s.inflight) begin
      w = ram[s.pc];
      s.inflight = 0;
      if (w == 16'd0) s.halted = 1;
      else begin
        s.holding = 1; s.ins = w; s.opc = s.pc; s.pc = s.pc + 8'd1;
      end
    end else if (s.holding) begin
      if (i_ready) s.holding = 0;
    end else if (!i_mem_busy) begin
      s.inflight = 1;
    end
    return s;
  endfunction

  // Compare process: check on the falling edge, advance the model on the rising edge.
  initial begin
    m[0] = mreset(rpc_of(0));
    m[1] = mreset(rpc_of(1));
    forever begin
      @(negedge i_clock);
      if (i_reset) for (int k = 0; k < 2; k++) m[k] = mreset(rpc_of(k));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("m%0d rd_en", k), 32'(w_rd[k]),
              32'(!i_reset && !m[k].inflight && !m[k].holding && !m[k].halted && !i_mem_busy));
        check($sformatf("m%0d addr", k),  32'(w_addr[k]),  32'(m[k].pc));
        check($sformatf("m%0d valid", k), 32'(w_valid[k]), 32'(m[k].holding));
        check($sformatf("m%0d halted", k),32'(w_halt[k]),  32'(m[k].halted));
        check($sformatf("m%0d instr", k), 32'(w_ins[k]),   32'(m[k].ins));
        check($sformatf("m%0d o_pc", k),  32'(w_pc[k]),    32'(m[k].opc));
      end
      @(posedge i_clock);
      for (int k = 0; k < 2; k++) m[k] = mstep(m[k], rpc_of(k));
    end
  end

  // ---------------- directed stimulus ----------------
  bit          cap_rd   [2][64];
  bit          cap_v    [2][64];
  bit          cap_h    [2][64];
  logic [15:0] cap_ins  [2][64];
  logic [7:0]  cap_pc   [2][64];
  logic [7:0]  cap_addr [2][64];

  // Called at posedge+1; records cycles start..start+n-1 and returns at posedge+1.
  task automatic capture(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge i_clock);
      for (int k = 0; k < 2; k++) begin
        cap_rd[k][i] = w_rd[k];     cap_v[k][i]   = w_valid[k];
        cap_h[k][i]  = w_halt[k];   cap_ins[k][i] = w_ins[k];
        cap_pc[k][i] = w_pc[k];     cap_addr[k][i] = w_addr[k];
      end
      @(posedge i_clock); #1;
    end
  endtask

  task automatic reset_dut();
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
  endtask

  task automatic clear_ram();
    for (int a = 0; a < 256; a++) ram[a] = 16'hFFFF;
  endtask

  initial begin
    // Test 1: straight-line program ending in a halt word.
    clear_ram();
    ram[0] = 16'h2101; ram[1] = 16'h2100; ram[2] = 16'h0000; ram[255] = 16'h0000;
    i_ready = 1'b1; i_mem_busy = 1'b0;
    @(posedge i_clock); #1;
    check("reset valid", 32'(w_valid[0]), 32'd0);
    check("reset halted", 32'(w_halt[0]), 32'd0);
    check("reset rd_en", 32'(w_rd[0]), 32'd0);
    check("reset instr", 32'(w_ins[0]), 32'h0);
    check("reset o_pc1", 32'(w_pc[1]), 32'd255);
    check("reset addr1", 32'(w_addr[1]), 32'd255);
    reset_dut();
    capture(0, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t1 rd c%0d", i), 32'(cap_rd[0][i]), 32'(i == 0 || i == 3 || i == 6));
      check($sformatf("t1 v c%0d", i),  32'(cap_v[0][i]),  32'(i == 2 || i == 5));
      check($sformatf("t1 h c%0d", i),  32'(cap_h[0][i]),  32'(i >= 8));
    end
    check("t1 pc c2", 32'(cap_pc[0][2]), 32'd0);
    check("t1 ins c2", 32'(cap_ins[0][2]), 32'h2101);
    check("t1 pc c5", 32'(cap_pc[0][5]), 32'd1);
    check("t1 ins c5", 32'(cap_ins[0][5]), 32'h2100);
    check("t1 addr c6", 32'(cap_addr[0][6]), 32'd2);

    // Test 2: backpressure holds the word, then release.
    clear_ram();
    ram[0] = 16'h4211; ram[1] = 16'h5555; ram[255] = 16'h7777;
    i_ready = 1'b0;
    reset_dut();
    capture(0, 12);
    i_ready = 1'b1;
    capture(12, 2);
    for (int i = 2; i <= 12; i++) begin
      check($sformatf("t2 v c%0d", i),   32'(cap_v[0][i]),   32'd1);
      check($sformatf("t2 ins c%0d", i), 32'(cap_ins[0][i]), 32'h4211);
      check($sformatf("t2 pc c%0d", i),  32'(cap_pc[0][i]),  32'd0);
    end
    for (int i = 1; i <= 12; i++)
      check($sformatf("t2 rd c%0d", i), 32'(cap_rd[0][i]), 32'd0);
    check("t2 v c13", 32'(cap_v[0][13]), 32'd0);
    check("t2 rd c13", 32'(cap_rd[0][13]), 32'd1);
    check("t2 addr c13", 32'(cap_addr[0][13]), 32'd1);

    // Test 3: busy at the first request, and busy during WAIT.
    clear_ram();
    ram[0] = 16'h1A2B; ram[255] = 16'h3C4D;
    i_ready = 1'b1; i_mem_busy = 1'b1;
    reset_dut();
    capture(0, 4);
    i_mem_busy = 1'b0;
    capture(4, 1);
    i_mem_busy = 1'b1;
    capture(5, 3);
    i_mem_busy = 1'b0;
    for (int i = 0; i < 4; i++)
      check($sformatf("t3 rd c%0d", i), 32'(cap_rd[0][i]), 32'd0);
    check("t3 rd c4", 32'(cap_rd[0][4]), 32'd1);
    check("t3 addr c4", 32'(cap_addr[0][4]), 32'd0);
    check("t3 rd c5", 32'(cap_rd[0][5]), 32'd0);
    check("t3 v c6", 32'(cap_v[0][6]), 32'd1);
    check("t3 ins c6", 32'(cap_ins[0][6]), 32'h1A2B);
    check("t3 rd c7", 32'(cap_rd[0][7]), 32'd0);

    // Test 4: PC wrap on the RESET_PC=255 instance.
    clear_ram();
    ram[255] = 16'h8123; ram[0] = 16'h6001; ram[1] = 16'h0000;
    i_ready = 1'b1;
    reset_dut();
    capture(0, 10);
    check("t4 addr c0", 32'(cap_addr[1][0]), 32'd255);
    check("t4 v c2", 32'(cap_v[1][2]), 32'd1);
    check("t4 pc c2", 32'(cap_pc[1][2]), 32'd255);
    check("t4 ins c2", 32'(cap_ins[1][2]), 32'h8123);
    check("t4 rd c3", 32'(cap_rd[1][3]), 32'd1);
    check("t4 addr c3", 32'(cap_addr[1][3]), 32'd0);
    check("t4 v c5", 32'(cap_v[1][5]), 32'd1);
    check("t4 pc c5", 32'(cap_pc[1][5]), 32'd0);
    check("t4 ins c5", 32'(cap_ins[1][5]), 32'h6001);
    check("t4 addr c6", 32'(cap_addr[1][6]), 32'd1);

    // Test 5: reset mid-WAIT discards the read; reset mid-HOLD drops valid at once.
    clear_ram();
    ram[0] = 16'h1111; ram[255] = 16'h2222;
    i_ready = 1'b0;
    reset_dut();
    capture(0, 1);
    #1;
    ram[0] = 16'h3333; ram[255] = 16'h4444;
    i_reset = 1'b1;
    #1;
    check("t5 wait rst rd", 32'(w_rd[0]), 32'd0);
    check("t5 wait rst v", 32'(w_valid[0]), 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    capture(0, 4);
    check("t5 rd c0", 32'(cap_rd[0][0]), 32'd1);
    check("t5 addr c0", 32'(cap_addr[0][0]), 32'd0);
    check("t5 ins c2", 32'(cap_ins[0][2]), 32'h3333);
    check("t5 v c3", 32'(cap_v[0][3]), 32'd1);
    check("t5 ins1 c2", 32'(cap_ins[1][2]), 32'h4444);
    #1;
    i_reset = 1'b1;
    #1;
    check("t5 hold rst v0", 32'(w_valid[0]), 32'd0);
    check("t5 hold rst v1", 32'(w_valid[1]), 32'd0);
    check("t5 hold rst ins", 32'(w_ins[0]), 32'h0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    capture(0, 3);
    check("t5b rd c0", 32'(cap_rd[0][0]), 32'd1);
    check("t5b addr c0", 32'(cap_addr[0][0]), 32'd0);
    check("t5b v c2", 32'(cap_v[0][2]), 32'd1);

    // Test 6: halt word at the reset address, ready toggling.
    clear_ram();
    ram[0] = 16'h0000; ram[255] = 16'h0000;
    reset_dut();
    for (int i = 0; i < 22; i++) begin
      i_ready = (i % 2 == 1);
      capture(i, 1);
    end
    for (int i = 0; i < 22; i++) begin
      check($sformatf("t6 v c%0d", i),  32'(cap_v[0][i]),  32'd0);
      check($sformatf("t6 h c%0d", i),  32'(cap_h[0][i]),  32'(i >= 2));
      check($sformatf("t6 rd c%0d", i), 32'(cap_rd[0][i]), 32'(i == 0));
    end
    check("t6 addr stays", 32'(w_addr[0]), 32'd0);
    #1;
    i_reset = 1'b1;
    #1;
    check("t6 rst h0", 32'(w_halt[0]), 32'd0);
    check("t6 rst h1", 32'(w_halt[1]), 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    capture(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
